fifo_stream_reader: RTL and testbench

- Consumer side of the control_fifo interface.
- Pops one WIDTH-bit word at a time from the FIFO and serializes it LSB-byte-first onto an 8-bit valid/ready stream.
- Flags the last byte of each word and keeps a running count of words sent.
- Sits between the FIFO datapath mux output and the downstream byte transmitter.

---
 rtl/fifo_stream_reader.sv | 102 ++++++++++
 tb/tb_fifo_stream_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_stream_reader: pops words from a FIFO, streams them LSB byte first.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fifo_stream_reader #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             fifo_pnding_i,
    input  logic [WIDTH-1:0] fifo_data_i,
    output logic             pop_o,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    output logic             tx_last_o,
    input  logic             tx_ready_i,
    output logic             busy_o,
    output logic [15:0]      words_o
);

    localparam int BYTES = WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [BCW-1:0] LAST_CNT = BCW'(BYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_POP  = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [BCW-1:0]   byte_cnt;
    logic [BCW-1:0]   byte_cnt_next;

    assign shreg_next    = shreg >> 8;
    assign byte_cnt_next = byte_cnt + 1'b1;

    // The word is captured on entry to POP, so the FIFO may advance its head
    // during the pop cycle without disturbing the bytes being streamed.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= S_IDLE;
            shreg      <= '0;
            byte_cnt   <= '0;
            pop_o      <= 1'b0;
            tx_data_o  <= 8'h00;
            tx_valid_o <= 1'b0;
            tx_last_o  <= 1'b0;
            busy_o     <= 1'b0;
            words_o    <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable_i && fifo_pnding_i) begin
                        shreg    <= fifo_data_i;
                        byte_cnt <= '0;
                        pop_o    <= 1'b1;
                        busy_o   <= 1'b1;
                        state    <= S_POP;
                    end
                end
                S_POP: begin
                    pop_o      <= 1'b0;
                    tx_valid_o <= 1'b1;
                    tx_data_o  <= shreg[7:0];
                    tx_last_o  <= (byte_cnt == LAST_CNT);
                    state      <= S_SEND;
                end
                S_SEND: begin
                    // tx_valid_o is always high here, so ready alone means accepted.
                    if (tx_ready_i) begin
                        shreg    <= shreg_next;
                        byte_cnt <= byte_cnt_next;
                        if (byte_cnt == LAST_CNT) begin
                            tx_valid_o <= 1'b0;
                            tx_last_o  <= 1'b0;
                            tx_data_o  <= 8'h00;
                            busy_o     <= 1'b0;
                            words_o    <= words_o + 16'd1;
                            state      <= S_IDLE;
                        end else begin
                            tx_data_o <= shreg_next[7:0];
                            tx_last_o <= (byte_cnt_next == LAST_CNT);
                        end
                    end
                end
                default: begin
                    pop_o      <= 1'b0;
                    tx_valid_o <= 1'b0;
                    tx_last_o  <= 1'b0;
                    busy_o     <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fifo_stream_reader: directed bench for fifo_stream_reader (WIDTH=32).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fifo_stream_reader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic        fifo_pnding_i;
    logic [31:0] fifo_data_i;
    logic        pop_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_last_o;
    logic        tx_ready_i;
    logic        busy_o;
    logic [15:0] words_o;

    fifo_stream_reader #(.WIDTH(32)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_i      (enable_i),
        .fifo_pnding_i (fifo_pnding_i),
        .fifo_data_i   (fifo_data_i),
        .pop_o         (pop_o),
        .tx_data_o     (tx_data_o),
        .tx_valid_o    (tx_valid_o),
        .tx_last_o     (tx_last_o),
        .tx_ready_i    (tx_ready_i),
        .busy_o        (busy_o),
        .words_o       (words_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic        en;
        logic        pn;
        logic [31:0] data;
        logic        rdy;
        logic        pop;
        logic        valid;
        logic        last;
        logic [7:0]  tdata;
        logic        busy;
        logic [15:0] words;
    } vec_t;

    vec_t        vecs [10];
    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          busy_cnt = 0;
    bit          model_on = 1'b0;
    logic [31:0] fifo_q [$];
    logic [7:0]  got [$];
    logic        got_last [$];
    int          pop_cyc [$];

    function automatic vec_t mk(logic rst, logic en, logic pn, logic [31:0] data, logic rdy,
                                logic pop, logic valid, logic last, logic [7:0] tdata,
                                logic busy, logic [15:0] words);
        vec_t v;
        v.rst = rst; v.en = en; v.pn = pn; v.data = data; v.rdy = rdy;
        v.pop = pop; v.valid = valid; v.last = last; v.tdata = tdata;
        v.busy = busy; v.words = words;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        if (model_on) begin
            fifo_pnding_i = (fifo_q.size() != 0);
            fifo_data_i   = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
        end
    endtask

    // Record what happened in the current cycle, then advance past the next edge.
    task automatic step();
        if (pop_o) begin
            pop_cyc.push_back(cyc);
            if (fifo_q.size() != 0) fifo_q.delete(0);
        end
        if (tx_valid_o && tx_ready_i) begin
            got.push_back(tx_data_o);
            got_last.push_back(tx_last_o);
        end
        if (busy_o) busy_cnt++;
        @(posedge clk_i);
        #1;
        cyc++;
        drive_fifo();
    endtask

    task automatic clear_mon();
        got.delete();
        got_last.delete();
        pop_cyc.delete();
        busy_cnt = 0;
    endtask

    task automatic check_word(input string name, input int base, input logic [31:0] w);
        logic [7:0] b;
        logic       l;
        for (int k = 0; k < 4; k++) begin
            b = (base + k < got.size()) ? got[base + k] : 8'hxx;
            l = (base + k < got_last.size()) ? got_last[base + k] : 1'bx;
            check($sformatf("%s byte%0d", name, k), 64'(b), 64'(w[8*k +: 8]));
            check($sformatf("%s last%0d", name, k), 64'(l), 64'(k == 3));
        end
    endtask

    initial begin
        vecs[0] = mk(0, 1, 1, 32'hA1B2C3D4, 1,  0, 0, 0, 8'h00, 0, 16'd0);
        vecs[1] = mk(0, 1, 1, 32'hA1B2C3D4, 1,  0, 0, 0, 8'h00, 0, 16'd0);
        vecs[2] = mk(1, 1, 0, 32'hA1B2C3D4, 1,  0, 0, 0, 8'h00, 0, 16'd0);
        vecs[3] = mk(1, 1, 1, 32'hA1B2C3D4, 1,  1, 0, 0, 8'h00, 1, 16'd0);
        vecs[4] = mk(1, 1, 0, 32'h00000000, 1,  0, 1, 0, 8'hD4, 1, 16'd0);
        vecs[5] = mk(1, 1, 0, 32'h00000000, 1,  0, 1, 0, 8'hC3, 1, 16'd0);
        vecs[6] = mk(1, 1, 0, 32'h00000000, 1,  0, 1, 0, 8'hB2, 1, 16'd0);
        vecs[7] = mk(1, 1, 0, 32'h00000000, 1,  0, 1, 1, 8'hA1, 1, 16'd0);
        vecs[8] = mk(1, 1, 0, 32'h00000000, 1,  0, 0, 0, 8'h00, 0, 16'd1);
        vecs[9] = mk(1, 1, 0, 32'h00000000, 1,  0, 0, 0, 8'h00, 0, 16'd1);

        for (int i = 0; i < 10; i++) begin
            rst_i         = vecs[i].rst;
            enable_i      = vecs[i].en;
            fifo_pnding_i = vecs[i].pn;
            fifo_data_i   = vecs[i].data;
            tx_ready_i    = vecs[i].rdy;
            step();
            check($sformatf("vec%0d", i),
                  64'({pop_o, tx_valid_o, tx_last_o, tx_data_o, busy_o, words_o}),
                  64'({vecs[i].pop, vecs[i].valid, vecs[i].last, vecs[i].tdata,
                       vecs[i].busy, vecs[i].words}));
        end

        // Backpressure on the second byte for three cycles.
        model_on = 1'b1;
        clear_mon();
        fifo_q.push_back(32'h11223344);
        drive_fifo();
        enable_i   = 1'b1;
        tx_ready_i = 1'b1;
        step();
        step();
        step();
        tx_ready_i = 1'b0;
        repeat (3) begin
            step();
            check("stall hold", 64'({pop_o, tx_valid_o, tx_last_o, tx_data_o}),
                  64'({1'b0, 1'b1, 1'b0, 8'h33}));
        end
        tx_ready_i = 1'b1;
        repeat (3) step();
        check_word("bp", 0, 32'h11223344);
        check("bp pops", 64'(pop_cyc.size()), 64'd1);
        check("bp words", 64'(words_o), 64'd2);
        check("bp busy cycles", 64'(busy_cnt), 64'd8);
        check("bp idle", 64'({busy_o, tx_valid_o}), 64'd0);

        // Three words back to back.
        clear_mon();
        fifo_q.push_back(32'hDEADBEEF);
        fifo_q.push_back(32'h01020304);
        fifo_q.push_back(32'hCAFE5A5A);
        drive_fifo();
        repeat (25) step();
        check("b2b pops", 64'(pop_cyc.size()), 64'd3);
        check("b2b spacing01", 64'(pop_cyc[1] - pop_cyc[0]), 64'd6);
        check("b2b spacing12", 64'(pop_cyc[2] - pop_cyc[1]), 64'd6);
        check("b2b bytes", 64'(got.size()), 64'd12);
        check_word("b2b w0", 0, 32'hDEADBEEF);
        check_word("b2b w1", 4, 32'h01020304);
        check_word("b2b w2", 8, 32'hCAFE5A5A);
        check("b2b words", 64'(words_o), 64'd5);

        // Enable dropped while the second byte is on the bus.
        clear_mon();
        fifo_q.push_back(32'hE0E1E2E3);
        fifo_q.push_back(32'h55667788);
        fifo_q.push_back(32'h99AABBCC);
        drive_fifo();
        step();
        step();
        step();
        enable_i = 1'b0;
        repeat (12) step();
        check("en pops", 64'(pop_cyc.size()), 64'd1);
        check_word("en", 0, 32'hE0E1E2E3);
        check("en words", 64'(words_o), 64'd6);
        check("en fifo left", 64'(fifo_q.size()), 64'd2);
        check("en idle", 64'({busy_o, pop_o, tx_valid_o}), 64'd0);

        // Reset after two bytes of a word have been accepted.
        clear_mon();
        enable_i = 1'b1;
        repeat (4) step();
        check("pre-reset bytes", 64'(got.size()), 64'd2);
        rst_i = 1'b0;
        #1;
        check("reset outputs", 64'({pop_o, tx_valid_o, tx_last_o, tx_data_o, busy_o}), 64'd0);
        check("reset words", 64'(words_o), 64'd0);
        repeat (2) step();
        rst_i = 1'b1;
        clear_mon();
        repeat (8) step();
        check_word("post-reset", 0, 32'h99AABBCC);
        check("post-reset pops", 64'(pop_cyc.size()), 64'd1);
        check("post-reset words", 64'(words_o), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
